// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, sticky error flags and flush.
// Latency: one cycle from an accepted read to rd_data/rd_valid; all status outputs are registered and settle one cycle after the causing edge.
// Backpressure: writes are dropped while full and set overflow; reads are ignored while empty and set underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    // Thresholds and depth resized once to the count width so every compare
    // below is between equal-width unsigned values.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Storage is never reset; only the pointers and count define contents.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_nxt;

    logic empty_q;
    logic full_q;
    logic af_q;
    logic ae_q;
    logic ovf_q;
    logic unf_q;

    logic wr_acc;
    logic rd_acc;
    logic wr_rej;
    logic rd_rej;

    // Accept/reject decisions use the registered flags, so a full FIFO with
    // both requests pops and drops the write, and an empty FIFO with both
    // requests pushes and rejects the read.
    always_comb begin
        wr_acc = wr_en & ~full_q;
        rd_acc = rd_en & ~empty_q;
        wr_rej = wr_en & full_q;
        rd_rej = rd_en & empty_q;
    end

    // Next occupancy; flush wins over any concurrent request.
    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count_q + ONE_C;
                2'b01:   count_nxt = count_q - ONE_C;
                default: count_nxt = count_q;
            endcase
        end
    end

    // Storage write port; a write coinciding with flush is discarded.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Occupancy and level flags, all derived from the next-state count so
    // they line up with the count output in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == DEPTH_C);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
        end
    end

    // Sticky error flags: set by any rejected request, cleared only by flush
    // or reset. Flush takes priority over a rejection in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_rej) begin
                ovf_q <= 1'b1;
            end
            if (rd_rej) begin
                unf_q <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Last popped word, shown while the FIFO is empty so rd_data never
    // exposes stale storage after reset or a drain.
    logic [DATA_W-1:0] rd_hold_q;

    // Capture the head as it leaves; flush leaves the held word untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hold_q <= '0;
        end else if (rd_acc && !flush) begin
            rd_hold_q <= mem[rd_ptr_q];
        end
    end

    // Head word falls through directly from storage whenever data is present.
    always_comb begin
        rd_valid = ~empty_q;
        rd_data  = empty_q ? rd_hold_q : mem[rd_ptr_q];
    end
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Registered read port: an accepted pop loads rd_data and strobes
    // rd_valid for exactly one cycle; otherwise rd_data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Drive the read outputs straight from their registers.
    always_comb begin
        rd_valid = rd_valid_q;
        rd_data  = rd_data_q;
    end
`endif

    // Status outputs come straight from registers.
    always_comb begin
        empty        = empty_q;
        full         = full_q;
        almost_full  = af_q;
        almost_empty = ae_q;
        count        = count_q;
        overflow     = ovf_q;
        underflow    = unf_q;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's fixed 32-bit synchronous FIFO.
- Adds configurable width and depth, occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a read-valid strobe.
- Sits between producer/consumer datapath stages in the same clock domain.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 1024, number of entries; must be a power of 2, at least 4.
- ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all contents and error flags
- wr_en  input  1  write request
- wr_data  input  DATA_W  write word
- rd_en  input  1  read request (pop)
- rd_data  output  DATA_W  read word
- rd_valid  output  1  rd_data holds a newly popped word
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was attempted while full
- underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Reset mid-operation discards all contents; storage RAM itself is not cleared.
- Write accept = wr_en & !full. An accepted write stores wr_data at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accept = rd_en & !empty. An accepted read registers mem[rd_ptr] into rd_data on the same edge; rd_ptr increments modulo DEPTH.
  - Latency is 1 cycle: rd_valid = 1 in the cycle after an accepted read, 0 otherwise.
  - rd_data holds its value when no read is accepted.
- Rejected requests:
  - wr_en while full: write is dropped, contents unchanged, overflow set to 1.
  - rd_en while empty: no pop, rd_valid = 0, underflow set to 1.
  - Both flags stay set until flush or reset.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted.
- Simultaneous cases:
  - Full with wr_en & rd_en: read accepted, write rejected (overflow set); count goes to DEPTH-1.
  - Empty with wr_en & rd_en: write accepted, read rejected (underflow set); count goes to 1.
- Status outputs: all flags and count are registered, computed from next-state count, so they are valid in the cycle after the causing edge. No combinational input-to-output paths.
- First write into an empty FIFO: empty deasserts 1 cycle after the write edge. Write-to-readable latency is 1 cycle.
- flush (synchronous) has priority over wr_en and rd_en in the same cycle:
  - pointers = 0, count = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - rd_data holds its value.
- Pointer wrap: ADDR_W-bit pointers wrap from DEPTH-1 to 0. full/empty are derived from count, not from pointer comparison.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data always presents the head word whenever the FIFO is not empty.
  - rd_valid = !empty.
  - rd_en pops the head; the next word appears in the following cycle.
  - Head word is visible 1 cycle after the first write into an empty FIFO.
- Undefined: standard mode exactly as in Behaviour.
- Both modes: identical count, flags, error and flush behaviour.

Test Plan:
1. Reset then fill (defaults): rst_n low 2 cycles, then write 0..9 on consecutive cycles, then rd_en for 10 cycles -> rd_data = 0..9 in order, each 1 cycle after its rd_en with rd_valid = 1; count returns to 0; empty = 1.
2. Fill to full: write 1024 words -> full = 1 and count = 1024 after the 1024th edge; almost_full = 1 from count = 1020; 1025th write dropped, overflow = 1; subsequent reads return 0..1023 intact.
3. Read on empty: rd_en with count = 0 -> rd_valid = 0, underflow = 1, count stays 0; then flush pulse -> underflow = 0.
4. Simultaneous read/write at count = 5 for 20 cycles with incrementing data -> count stays 5; output order preserved; no error flags.
5. Wrap and flush: write/read 3000 words with random gaps -> data order preserved across pointer wrap. Then flush together with wr_en at count = 7 -> count = 0 and empty = 1 next cycle; the concurrent write is discarded.
6. FWFT build (SYNC_FIFO_FWFT_EN defined): write 0xA5 into empty FIFO -> next cycle rd_valid = 1 and rd_data = 0xA5 with no rd_en; one rd_en -> empty = 1 the following cycle. Asynchronous rst_n pulse mid-stream -> all outputs at reset values immediately.
